// File: rtl/gpc2311_5_bist.sv
// rtl/gpc2311_5_bist.sv - exhaustive BIST sweep for a gpc2311_5 counter (all 128 vectors, weighted-sum check)
// Optional: define GPC_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gpc2311_5_bist #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             src0,
  output logic             src1,
  output logic [2:0]       src2,
  output logic [1:0]       src3,
  input  logic [4:0]       dst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_vec,
  output logic [4:0]       fail_dst
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  state_t          state;
  state_t          state_nx;
  logic [6:0]      vec;
  logic [CW-1:0]   settle;
  logic [1:0]      w4;
  logic [1:0]      w8;
  logic [4:0]      exp_sum;
  logic            mismatch;
  logic            stop_now;
  logic            start_ok;
  logic            last_vec;

  // src outputs come straight off the vector register so the counter sees no glitches
  assign src0 = vec[0];
  assign src1 = vec[1];
  assign src2 = vec[4:2];
  assign src3 = vec[6:5];

  assign w4       = {1'b0, vec[2]} + {1'b0, vec[3]} + {1'b0, vec[4]};
  assign w8       = {1'b0, vec[5]} + {1'b0, vec[6]};
  assign exp_sum  = {4'b0, vec[0]} + {3'b0, vec[1], 1'b0} + {1'b0, w4, 2'b0} + {w8, 3'b0};
  assign mismatch = (state == CHECK) && (dst != exp_sum);
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign last_vec = (vec == 7'h7f);

`ifdef GPC_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = WAIT;
      WAIT:       if (settle == '0) state_nx = CHECK;
      CHECK:      state_nx = (last_vec || stop_now) ? DONE : WAIT;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WAIT) || (state == CHECK);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= '0;
      settle    <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_dst  <= '0;
      pass      <= 1'b0;
    end else if (start_ok) begin
      vec       <= '0;
      settle    <= RELOAD;
      err_count <= '0;
      fail_vec  <= '0;
      fail_dst  <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        WAIT: if (settle != '0) settle <= settle - CW'(1);
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            // first-fail capture keys off the pre-increment zero, so saturation never re-arms it
            if (err_count == '0) begin
              fail_vec <= vec;
              fail_dst <= dst;
            end
          end
          if (last_vec || stop_now) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec    <= vec + 7'd1;
            settle <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
